// File: rtl/motion_dir_sequencer_pkg.sv
// motion_pkg: shared definitions for the motion direction path.
// The sequencer and the downstream H-bridge decoder both import this package.
//   DIR_*        : 4-bit motion direction codes (5..15 are illegal)
//   state_t      : sequencer control states
//   dir_is_legal : true for codes REST..LEFT
package motion_pkg;

    localparam logic [3:0] DIR_REST  = 4'd0;
    localparam logic [3:0] DIR_FWD   = 4'd1;
    localparam logic [3:0] DIR_BWD   = 4'd2;
    localparam logic [3:0] DIR_RIGHT = 4'd3;
    localparam logic [3:0] DIR_LEFT  = 4'd4;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DEAD  = 2'd1,
        S_ESTOP = 2'd2
    } state_t;

    function automatic logic dir_is_legal(input logic [3:0] dir);
        return (dir <= DIR_LEFT);
    endfunction

endpackage

// File: rtl/motion_dir_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input level
//   q     : synchronized level, two clk edges of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/motion_dir_sequencer.sv
// motion_dir_sequencer: accepts motion requests on a valid/ready handshake and
// drives the motion direction code for the H-bridge decoder. Switching between
// two different non-REST motions inserts a REST dead time; every change of
// motiondir is followed by a minimum hold before the next request is taken;
// a synchronized emergency stop forces REST.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   cmd_dir   : requested motion code
//   cmd_valid : request valid
//   cmd_ready : request may be accepted this cycle (registered)
//   estop     : asynchronous emergency stop level, active high
//   motiondir : motion code to the decoder (registered)
//   busy      : state != S_RUN or hold counter != 0 (registered)
//   cmd_err   : one-cycle pulse when an illegal code is accepted (registered)
module motion_dir_sequencer
    import motion_pkg::*;
#(
    parameter int DEADTIME_CYCLES = 100000,
    parameter int MIN_HOLD_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cmd_dir,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       estop,
    output logic [3:0] motiondir,
    output logic       busy,
    output logic       cmd_err
);

    localparam int CNT_MAX = (DEADTIME_CYCLES > MIN_HOLD_CYCLES) ? DEADTIME_CYCLES
                                                                 : MIN_HOLD_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_HOLD_CYCLES);
    // The dead counter counts down to 0 inclusive, hence the -1.
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEADTIME_CYCLES - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   dead_q, dead_d;
    logic [3:0]      pending_q, pending_d;
    logic [3:0]      dir_d;
    logic            err_d;
    logic            ready_d;
    logic            busy_d;
    logic            estop_s;
    logic            accept;

    sync_2ff u_estop_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (estop),
        .q     (estop_s)
    );

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        hold_d    = (hold_q != '0) ? (hold_q - 1'b1) : hold_q;
        dead_d    = dead_q;
        pending_d = pending_q;
        dir_d     = motiondir;
        err_d     = 1'b0;

        if (estop_s && (state_q != S_ESTOP)) begin
            // Emergency stop overrides any accept, dead time or hold in flight.
            state_d   = S_ESTOP;
            dir_d     = DIR_REST;
            pending_d = DIR_REST;
            hold_d    = '0;
            dead_d    = '0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (accept) begin
                        if (!dir_is_legal(cmd_dir)) begin
                            err_d = 1'b1;
                        end else if (cmd_dir == motiondir) begin
                            // Repeat of the current motion: nothing to do.
                        end else if ((cmd_dir == DIR_REST) || (motiondir == DIR_REST)) begin
                            dir_d  = cmd_dir;
                            hold_d = HOLD_LOAD;
                        end else begin
                            dir_d     = DIR_REST;
                            pending_d = cmd_dir;
                            dead_d    = DEAD_LOAD;
                            state_d   = S_DEAD;
                        end
                    end
                end
                S_DEAD: begin
                    if (dead_q == '0) begin
                        state_d   = S_RUN;
                        dir_d     = pending_q;
                        // After an estop recovery pending is REST and motiondir
                        // does not change, so no hold is owed.
                        hold_d    = (pending_q != DIR_REST) ? HOLD_LOAD : '0;
                        pending_d = DIR_REST;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                S_ESTOP: begin
                    dir_d  = DIR_REST;
                    hold_d = '0;
                    if (!estop_s) begin
                        state_d   = S_DEAD;
                        pending_d = DIR_REST;
                        dead_d    = DEAD_LOAD;
                    end
                end
                default: begin
                    state_d   = S_RUN;
                    dir_d     = DIR_REST;
                    pending_d = DIR_REST;
                    hold_d    = '0;
                    dead_d    = '0;
                end
            endcase
        end

        // Outputs are registered, so they are derived from next-state values.
        ready_d = (state_d == S_RUN) && (hold_d == '0) && !estop_s;
        busy_d  = (state_d != S_RUN) || (hold_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            hold_q    <= '0;
            dead_q    <= '0;
            pending_q <= DIR_REST;
            motiondir <= DIR_REST;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            dead_q    <= dead_d;
            pending_q <= pending_d;
            motiondir <= dir_d;
            cmd_ready <= ready_d;
            busy      <= busy_d;
            cmd_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_motion_dir_sequencer.sv
// Directed bench for motion_dir_sequencer with DEADTIME_CYCLES=4, MIN_HOLD_CYCLES=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_motion_dir_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cmd_dir;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       estop;
    logic [3:0] motiondir;
    logic       busy;
    logic       cmd_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    motion_dir_sequencer #(
        .DEADTIME_CYCLES (4),
        .MIN_HOLD_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_dir   (cmd_dir),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .estop     (estop),
        .motiondir (motiondir),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a request for one cycle; caller guarantees cmd_ready is high.
    task automatic send(input logic [3:0] d);
        cmd_dir   = d;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        chk("wait_ready", {7'd0, cmd_ready}, 8'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_dir   = 4'd0;
        cmd_valid = 1'b0;
        estop     = 1'b0;
        repeat (3) step();
        chk("rst_motiondir", {4'd0, motiondir}, 8'd0);
        chk("rst_ready",     {7'd0, cmd_ready}, 8'd0);
        chk("rst_busy",      {7'd0, busy},      8'd0);
        chk("rst_err",       {7'd0, cmd_err},   8'd0);

        // Reset release, then FWD
        rst_n = 1'b1;
        step();
        chk("rel_ready", {7'd0, cmd_ready}, 8'd1);
        send(4'd1);
        chk("fwd_dir",    {4'd0, motiondir}, 8'd1);
        chk("fwd_ready1", {7'd0, cmd_ready}, 8'd0);
        chk("fwd_busy1",  {7'd0, busy},      8'd1);
        step();
        chk("fwd_ready2", {7'd0, cmd_ready}, 8'd0);
        step();
        chk("fwd_ready3", {7'd0, cmd_ready}, 8'd0);
        chk("fwd_busy3",  {7'd0, busy},      8'd1);
        step();
        chk("fwd_ready4", {7'd0, cmd_ready}, 8'd1);
        chk("fwd_busy4",  {7'd0, busy},      8'd0);

        // FWD -> BWD through dead time
        send(4'd2);
        chk("fb_dir1",   {4'd0, motiondir}, 8'd0);
        chk("fb_ready1", {7'd0, cmd_ready}, 8'd0);
        chk("fb_busy1",  {7'd0, busy},      8'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("fb_dead", {4'd0, motiondir}, 8'd0);
        end
        step();
        chk("fb_dir5",   {4'd0, motiondir}, 8'd2);
        chk("fb_ready5", {7'd0, cmd_ready}, 8'd0);
        step();
        step();
        chk("fb_ready7", {7'd0, cmd_ready}, 8'd0);
        step();
        chk("fb_ready8", {7'd0, cmd_ready}, 8'd1);

        // Illegal code
        send(4'd7);
        chk("ill_err",   {7'd0, cmd_err},   8'd1);
        chk("ill_dir",   {4'd0, motiondir}, 8'd2);
        chk("ill_ready", {7'd0, cmd_ready}, 8'd1);
        step();
        chk("ill_err_clr", {7'd0, cmd_err}, 8'd0);

        // Repeat of current code
        send(4'd2);
        chk("rep_dir",   {4'd0, motiondir}, 8'd2);
        chk("rep_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rep_busy",  {7'd0, busy},      8'd0);

        // Reach RIGHT via REST
        send(4'd0);
        wait_ready();
        send(4'd3);
        wait_ready();
        chk("right_dir", {4'd0, motiondir}, 8'd3);

        // Direct stop, then restart LEFT
        send(4'd0);
        chk("stop_dir",   {4'd0, motiondir}, 8'd0);
        chk("stop_ready", {7'd0, cmd_ready}, 8'd0);
        step();
        step();
        chk("stop_ready3", {7'd0, cmd_ready}, 8'd0);
        step();
        chk("stop_ready4", {7'd0, cmd_ready}, 8'd1);
        send(4'd4);
        chk("left_dir", {4'd0, motiondir}, 8'd4);

        // Set up FWD
        wait_ready();
        send(4'd0);
        wait_ready();
        send(4'd1);
        wait_ready();
        chk("fwd2_dir", {4'd0, motiondir}, 8'd1);

        // FWD -> LEFT with estop during dead time
        send(4'd4);
        chk("es_dead_dir", {4'd0, motiondir}, 8'd0);
        estop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("es_hold_dir",   {4'd0, motiondir}, 8'd0);
            chk("es_hold_ready", {7'd0, cmd_ready}, 8'd0);
        end
        chk("es_busy", {7'd0, busy}, 8'd1);
        estop = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("es_rel_dir",   {4'd0, motiondir}, 8'd0);
            chk("es_rel_ready", {7'd0, cmd_ready}, 8'd0);
        end
        step();
        chk("es_done_ready", {7'd0, cmd_ready}, 8'd1);
        chk("es_done_dir",   {4'd0, motiondir}, 8'd0);
        chk("es_done_busy",  {7'd0, busy},      8'd0);

        // Async reset mid-hold
        send(4'd2);
        chk("ar_dir", {4'd0, motiondir}, 8'd2);
        chk("ar_ready_pre", {7'd0, cmd_ready}, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_dir_rst",   {4'd0, motiondir}, 8'd0);
        chk("ar_ready_rst", {7'd0, cmd_ready}, 8'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_ready_rel", {7'd0, cmd_ready}, 8'd1);
        chk("ar_dir_rel",   {4'd0, motiondir}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/motion_dir_sequencer.md
Name: motion_dir_sequencer

Overview:
- Sits directly upstream of the H-bridge decoder. It accepts motion requests over a valid/ready handshake and drives the 4-bit motion direction code that the decoder turns into bridge pins.
- Its job is safe direction changes:
  - a coast (REST) dead-time whenever the motor switches between two non-REST motions;
  - a minimum hold time after every accepted change;
  - a synchronized emergency stop that forces REST.

Parameters:
DEADTIME_CYCLES, 100000, cycles motiondir is held at REST between two different non-REST codes (>=1)
MIN_HOLD_CYCLES, 1000000, cycles cmd_ready stays low after motiondir changes (>=0)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_dir  in  4  requested motion code
cmd_valid  in  1  request valid
cmd_ready  out  1  request may be accepted this cycle
estop  in  1  emergency stop, asynchronous level, active high
motiondir  out  4  motion code to the H-bridge decoder
busy  out  1  high when state != S_RUN or hold counter != 0
cmd_err  out  1  one-cycle pulse when an illegal code is accepted

Behaviour:
- Encoding: 0 REST, 1 FWD, 2 BWD, 3 RIGHT, 4 LEFT. Codes 5..15 are illegal.
- Reset (async, rst_n low):
  - Outputs: motiondir=0, cmd_ready=0, cmd_err=0, busy=0.
  - Internal: state=S_RUN, hold counter=0, dead counter=0, pending=0, estop sync flops=0.
  - Timing: cmd_ready rises on the first clk edge after rst_n deasserts.
- All outputs are registered. cmd_ready=1 only when state==S_RUN, hold counter==0 and synced estop==0.
- Accept = cmd_valid && cmd_ready, at cycle N. Cases:
  - Illegal code: cmd_err=1 at N+1 only; no other change; hold counter not loaded.
  - cmd_dir==motiondir: no change; hold counter not loaded.
  - cmd_dir==0, or motiondir==0 (RUN path): motiondir=cmd_dir at N+1; hold counter loaded with MIN_HOLD_CYCLES at N+1.
  - Both non-zero and different (dead path): motiondir=0 at N+1; pending=cmd_dir; state=S_DEAD; dead counter loaded with DEADTIME_CYCLES-1.
- Hold counter:
  - Decrements each cycle while non-zero.
  - cmd_ready is low N+1..N+MIN_HOLD_CYCLES and high again at N+MIN_HOLD_CYCLES+1.
  - With MIN_HOLD_CYCLES=0, cmd_ready never drops.
- S_DEAD:
  - motiondir=0 for exactly DEADTIME_CYCLES cycles (N+1..N+DEADTIME_CYCLES).
  - At N+DEADTIME_CYCLES+1: motiondir=pending, state=S_RUN, hold counter loaded with MIN_HOLD_CYCLES.
  - cmd_ready=0 throughout.
- estop:
  - Passes through a 2-flop synchronizer (2-cycle latency). Synced estop rising has priority over everything.
  - Next cycle: motiondir=0, state=S_ESTOP, pending discarded, hold counter cleared, cmd_ready=0.
  - This applies mid-dead-time and mid-hold as well.
- S_ESTOP exit:
  - On synced estop falling: state=S_DEAD with pending=0, dead counter loaded with DEADTIME_CYCLES-1.
  - After the dead time, returns to S_RUN with motiondir=0 and hold counter=0, so cmd_ready is immediately high.
- Counters: width $clog2(max(DEADTIME_CYCLES,MIN_HOLD_CYCLES)+1). No wrap; they saturate at 0.
- cmd_valid while cmd_ready=0 has no effect; the requester must hold the request.
- cmd_ready does not depend on cmd_valid or cmd_dir.

Decomposition:
- Package motion_pkg holds:
  - localparams DIR_REST/DIR_FWD/DIR_BWD/DIR_RIGHT/DIR_LEFT;
  - the state enum S_RUN/S_DEAD/S_ESTOP;
  - function dir_is_legal.
- The decoder downstream imports the same package.
- One sub-module: sync_2ff (1-bit, async active-low reset to 0), used for estop.

Test Plan (DEADTIME_CYCLES=4, MIN_HOLD_CYCLES=3):
- Reset then FWD:
  - Stimulus: release rst_n; cmd_dir=1, cmd_valid=1 at the first ready cycle N.
  - Required: motiondir=1 at N+1; cmd_ready low N+1..N+3, high at N+4; busy mirrors this.
- FWD->BWD:
  - Stimulus: request 2 while motiondir=1.
  - Required: motiondir=0 at N+1..N+4; motiondir=2 at N+5; cmd_ready high at N+8.
- Illegal and repeat codes:
  - cmd_dir=7 -> cmd_err=1 for one cycle; motiondir unchanged; cmd_ready stays high.
  - cmd_dir=motiondir -> no change; no hold.
- Direct stop and restart:
  - Stimulus: motiondir=3, request 0; after hold, request 4.
  - Required: 3->0 at N+1 with no dead time; then 0->4 at the cycle after acceptance with no dead time.
- estop mid-dead-time:
  - Stimulus: assert estop during the FWD->LEFT dead time.
  - Required: motiondir stays 0 and pending LEFT is never output. After estop deassert plus 2-cycle sync, 4 dead cycles elapse, then cmd_ready=1 with motiondir=0.
- Async reset mid-hold:
  - Stimulus: pull rst_n low while motiondir=2 and the hold counter is non-zero.
  - Required: motiondir=0 and cmd_ready=0 immediately (no clock); cmd_ready=1 on the first edge after release.
